// File: rtl/sub_deparser_seq.sv
// sub_deparser_seq: serialises the emittable container values of one PHV as a valid/ready beat stream
// in ascending action order, with last on the final beat and a done pulse per PHV.
module sub_deparser_seq #(
  parameter int C_PKT_VEC_WIDTH = 1124,
  parameter int C_PHV_BASE = 356,
  parameter int C_NUM_CONT = 8,
  parameter int C_IDX_W = 3,
  parameter int C_NUM_ACTS = 10,
  localparam int C_ACT_LEN = 2 + C_IDX_W + 1,
  localparam int AW = C_NUM_ACTS > 1 ? $clog2(C_NUM_ACTS) : 1
) (
  input  logic                            clk,
  input  logic                            aresetn,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [C_PKT_VEC_WIDTH-1:0]      phv_in,
  input  logic [C_NUM_ACTS*C_ACT_LEN-1:0] acts_in,
  output logic                            val_out_valid,
  input  logic                            val_out_ready,
  output logic [47:0]                     val_out,
  output logic [1:0]                      val_out_type,
  output logic [AW-1:0]                   val_out_act,
  output logic                            val_out_last,
  output logic                            done
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [C_PKT_VEC_WIDTH-1:0] phv;
  logic [C_NUM_ACTS*C_ACT_LEN-1:0] acts;
  logic [C_NUM_ACTS-1:0] mask, emit;
  logic [AW-1:0] k;
  logic [1:0] typ;
  logic [C_IDX_W-1:0] idx;
  logic [47:0] slot;
  int off;
  always_comb begin
    emit = '0;
    for (int i = 0; i < C_NUM_ACTS; i++) begin
      logic [C_ACT_LEN-1:0] a;
      a = acts_in[i*C_ACT_LEN +: C_ACT_LEN];
      emit[i] = a[0] && a[C_ACT_LEN-1 -: 2] != 2'b00 && int'(a[C_IDX_W:1]) < C_NUM_CONT;
    end
  end
  // mask holds the actions still to be emitted; its lowest set bit is the next beat
  always_comb begin
    k = '0;
    for (int i = C_NUM_ACTS - 1; i >= 0; i--) if (mask[i]) k = AW'(i);
    typ = acts[int'(k)*C_ACT_LEN + C_ACT_LEN - 2 +: 2];
    idx = acts[int'(k)*C_ACT_LEN + 1 +: C_IDX_W];
    off = C_PHV_BASE + (typ == 2'b01 ? 0 : typ == 2'b10 ? 16*C_NUM_CONT : 48*C_NUM_CONT)
        + 16*int'(typ)*int'(idx);
    slot = 48'(phv >> off) & (typ == 2'b01 ? 48'h0000_0000_FFFF :
                              typ == 2'b10 ? 48'h0000_FFFF_FFFF : 48'hFFFF_FFFF_FFFF);
  end
  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) begin
      state <= IDLE;
      in_ready <= 1'b0;
      phv <= '0;
      acts <= '0;
      mask <= '0;
      val_out_valid <= 1'b0;
      val_out <= '0;
      val_out_type <= '0;
      val_out_act <= '0;
      val_out_last <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        in_ready <= 1'b1;
        if (in_valid && in_ready) begin
          phv <= phv_in;
          acts <= acts_in;
          mask <= emit;
          if (|emit) begin
            state <= RUN;
            in_ready <= 1'b0;
          end else done <= 1'b1;
        end
      end else if (val_out_valid && val_out_ready && val_out_last) begin
        state <= IDLE;
        in_ready <= 1'b1;
        done <= 1'b1;
        val_out_valid <= 1'b0;
        val_out_last <= 1'b0;
        val_out <= '0;
        val_out_type <= '0;
        val_out_act <= '0;
      end else if ((!val_out_valid || val_out_ready) && |mask) begin
        val_out <= slot;
        val_out_type <= typ;
        val_out_act <= k;
        val_out_last <= $onehot(mask);
        mask[k] <= 1'b0;
        val_out_valid <= 1'b1;
      end
    end
endmodule
